// File: rtl/mul_4x4_i8_rdr_pkg.sv
// Shared types, sizing and lane scaling for the 4x4 int8 multiplier result reader.
package mul_4x4_i8_rdr_pkg;

    localparam int unsigned MUL_LATENCY = 7;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned RES_W       = 18;
    localparam int unsigned EXT_W       = RES_W + 1;
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1);

    localparam logic signed [EXT_W-1:0] SAT_MAX_S = EXT_W'(127);
    localparam logic signed [EXT_W-1:0] SAT_MIN_S = EXT_W'(-128);

    typedef struct packed {
        logic       vld;
        logic       sgn;
        logic [3:0] shift;
    } tag_t;

    typedef struct packed {
        logic [3:0]  sat;
        logic [31:0] data;
    } entry_t;

    typedef struct packed {
        tag_t   [MUL_LATENCY-1:0] tags;
        entry_t [FIFO_DEPTH-1:0]  fifo;
        logic   [PTR_W:0]         wr_ptr;
        logic   [PTR_W:0]         rd_ptr;
        logic   [CNT_W-1:0]       reserved;
        logic                     ovf;
    } mul_4x4_i8_rdr_registers;

    localparam mul_4x4_i8_rdr_registers mul_4x4_i8_rdr_r_reset = '0;

    // Round half up, shift, clamp to 8 bits; returns {sat, q}.
    function automatic logic [8:0] lane_scale(input logic [RES_W-1:0] x, input logic sgn,
                                              input logic [3:0] shift);
        logic        [EXT_W-1:0] ext;
        logic        [EXT_W-1:0] rnd;
        logic        [EXT_W-1:0] uq;
        logic signed [EXT_W-1:0] sq;
        logic        [8:0]       res;
        ext = sgn ? {x[RES_W-1], x} : {1'b0, x};
        rnd = (shift != 4'd0) ? ext + (EXT_W'(1) << (shift - 4'd1)) : ext;
        sq  = $signed(rnd) >>> shift;
        uq  = rnd >> shift;
        if (sgn) begin
            if (sq > SAT_MAX_S)      res = {1'b1, 8'h7F};
            else if (sq < SAT_MIN_S) res = {1'b1, 8'h80};
            else                     res = {1'b0, sq[7:0]};
        end else begin
            if (uq > EXT_W'(255))    res = {1'b1, 8'hFF};
            else                     res = {1'b0, uq[7:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_4x4_i8_rdr.sv
// Result reader: tags in-flight issues, scales the four result lanes and buffers
// packed words in a credit-protected FIFO.
import mul_4x4_i8_rdr_pkg::*;

module mul_4x4_i8_rdr (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_issue,
    input  logic             i_signed,
    input  logic [3:0]       i_shift,
    output logic             o_issue_ready,
    input  logic [RES_W-1:0] i_res0,
    input  logic [RES_W-1:0] i_res1,
    input  logic [RES_W-1:0] i_res2,
    input  logic [RES_W-1:0] i_res3,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_data,
    output logic [3:0]       o_sat,
    output logic             o_ovf
);

    mul_4x4_i8_rdr_registers r, rin;

    tag_t             exit_tag;
    logic             accept;
    logic             pop;
    logic             push;
    logic             empty;
    logic             full;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic [8:0]       q0, q1, q2, q3;

    assign wr_idx   = r.wr_ptr[PTR_W-1:0];
    assign rd_idx   = r.rd_ptr[PTR_W-1:0];
    assign empty    = (r.wr_ptr == r.rd_ptr);
    assign full     = (r.wr_ptr[PTR_W] != r.rd_ptr[PTR_W]) && (wr_idx == rd_idx);
    assign accept   = i_issue & o_issue_ready;
    assign pop      = ~empty & i_ready;
    assign exit_tag = r.tags[MUL_LATENCY-1];
    assign push     = exit_tag.vld;

    assign q0 = lane_scale(i_res0, exit_tag.sgn, exit_tag.shift);
    assign q1 = lane_scale(i_res1, exit_tag.sgn, exit_tag.shift);
    assign q2 = lane_scale(i_res2, exit_tag.sgn, exit_tag.shift);
    assign q3 = lane_scale(i_res3, exit_tag.sgn, exit_tag.shift);

    // Next-state: tag pipe shift, FIFO push/pop, credit and sticky overflow update.
    always_comb begin
        rin = r;
        for (int i = MUL_LATENCY - 1; i > 0; i--) begin
            rin.tags[i] = r.tags[i-1];
        end
        rin.tags[0] = '{vld: accept, sgn: i_signed, shift: i_shift};
        if (push) begin
            rin.fifo[wr_idx] = '{sat:  {q3[8], q2[8], q1[8], q0[8]},
                                 data: {q3[7:0], q2[7:0], q1[7:0], q0[7:0]}};
            rin.wr_ptr = r.wr_ptr + (PTR_W+1)'(1);
        end
        if (pop) begin
            rin.rd_ptr = r.rd_ptr + (PTR_W+1)'(1);
        end
        rin.reserved = r.reserved + CNT_W'(accept) - CNT_W'(pop);
        if (i_issue && !o_issue_ready) begin
            rin.ovf = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) r <= mul_4x4_i8_rdr_r_reset;
        else         r <= rin;
    end

    // Credits reserve a slot at issue time, so a push can never meet a full FIFO.
    push_never_full: assert property (@(posedge i_clk) disable iff (!i_nrst) !(push && full));

    assign o_issue_ready = (r.reserved < CNT_W'(FIFO_DEPTH));
    assign o_valid       = ~empty;
    assign o_data        = r.fifo[rd_idx].data;
    assign o_sat         = r.fifo[rd_idx].sat;
    assign o_ovf         = r.ovf;

endmodule

// File: tb/tb_mul_4x4_i8_rdr.sv
// Bench for mul_4x4_i8_rdr: multiplier delay model, credit/FIFO model and result scoreboard.
`timescale 1ns/1ps
module tb_mul_4x4_i8_rdr;

    localparam int LAT   = 7;
    localparam int DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_nrst, i_issue, i_signed, i_ready;
    logic [3:0]  i_shift;
    logic [17:0] i_res0, i_res1, i_res2, i_res3;
    logic        o_issue_ready, o_valid, o_ovf;
    logic [31:0] o_data;
    logic [3:0]  o_sat;

    logic [71:0] cur_vec;
    logic [71:0] mpipe [LAT];

    int          checks   = 0;
    int          failures = 0;
    int          m_res, m_cnt;
    logic [LAT-1:0] m_pipe;
    logic        m_ovf;
    logic [35:0] exp_q [$];

    assign i_res0 = mpipe[LAT-1][17:0];
    assign i_res1 = mpipe[LAT-1][35:18];
    assign i_res2 = mpipe[LAT-1][53:36];
    assign i_res3 = mpipe[LAT-1][71:54];

    always #5 i_clk = ~i_clk;

    mul_4x4_i8_rdr dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_issue(i_issue), .i_signed(i_signed),
        .i_shift(i_shift), .o_issue_ready(o_issue_ready),
        .i_res0(i_res0), .i_res1(i_res1), .i_res2(i_res2), .i_res3(i_res3),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_sat(o_sat), .o_ovf(o_ovf)
    );

    function automatic logic [8:0] model_lane(input logic [17:0] x, input logic sgn,
                                              input logic [3:0] sh);
        longint v;
        int     s;
        s = int'(sh);
        v = longint'(x);
        if (sgn && x[17]) v = v - 262144;
        if (s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (sgn) begin
            if (v > 127)  return {1'b1, 8'h7F};
            if (v < -128) return {1'b1, 8'h80};
        end else if (v > 255) begin
            return {1'b1, 8'hFF};
        end
        return {1'b0, v[7:0]};
    endfunction

    function automatic logic [35:0] model_word(input logic [71:0] vec, input logic sgn,
                                               input logic [3:0] sh);
        logic [31:0] d;
        logic [3:0]  s;
        logic [8:0]  l;
        for (int i = 0; i < 4; i++) begin
            l          = model_lane(vec[i*18 +: 18], sgn, sh);
            d[i*8 +: 8] = l[7:0];
            s[i]       = l[8];
        end
        return {s, d};
    endfunction

    function automatic logic [71:0] rand_vec();
        logic [71:0] v;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0:       v[i*18 +: 18] = 18'($urandom);
                1:       v[i*18 +: 18] = 18'($urandom_range(0, 600));
                default: v[i*18 +: 18] = 18'(-int'($urandom_range(0, 600)));
            endcase
        end
        return v;
    endfunction

    // One clock: check outputs against the model at negedge, advance model, shift multiplier pipe.
    task automatic cycle();
        logic acc, pop, push;
        @(negedge i_clk);
        if (!i_nrst) begin
            m_res = 0; m_cnt = 0; m_pipe = '0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            acc  = i_issue && (m_res < DEPTH);
            pop  = (m_cnt > 0) && i_ready;
            push = m_pipe[LAT-1];
            checks++;
            if (o_valid !== (m_cnt > 0)) begin
                failures++; $display("FAIL sb_valid got=%b want=%b t=%0t", o_valid, m_cnt > 0, $time);
            end
            checks++;
            if (o_issue_ready !== (m_res < DEPTH)) begin
                failures++; $display("FAIL sb_issue_ready got=%b want=%b t=%0t", o_issue_ready, m_res < DEPTH, $time);
            end
            checks++;
            if (o_ovf !== m_ovf) begin
                failures++; $display("FAIL sb_ovf got=%b want=%b t=%0t", o_ovf, m_ovf, $time);
            end
            if (m_cnt > 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL sb_underflow got=%h want=none t=%0t", {o_sat, o_data}, $time);
                end else begin
                    if ({o_sat, o_data} !== exp_q[0]) begin
                        failures++; $display("FAIL sb_word got=%h want=%h t=%0t", {o_sat, o_data}, exp_q[0], $time);
                    end
                    if (pop) void'(exp_q.pop_front());
                end
            end
            if (acc) exp_q.push_back(model_word(cur_vec, i_signed, i_shift));
            if (i_issue && !acc) m_ovf = 1'b1;
            m_res  = m_res + int'(acc) - int'(pop);
            m_cnt  = m_cnt + int'(push) - int'(pop);
            m_pipe = {m_pipe[LAT-2:0], acc};
        end
        @(posedge i_clk);
        #1;
        for (int i = LAT - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
        mpipe[0] = cur_vec;
    endtask

    task automatic test_reset();
        i_nrst = 1'b0; i_issue = 1'b0; i_ready = 1'b1; i_signed = 1'b0; i_shift = 4'd0;
        cycle(); cycle();
        i_nrst = 1'b1;
        checks++; if (o_valid !== 1'b0)       begin failures++; $display("FAIL reset_valid got=%b want=0", o_valid); end
        checks++; if (o_data !== 32'h0)       begin failures++; $display("FAIL reset_data got=%h want=0", o_data); end
        checks++; if (o_sat !== 4'h0)         begin failures++; $display("FAIL reset_sat got=%b want=0", o_sat); end
        checks++; if (o_ovf !== 1'b0)         begin failures++; $display("FAIL reset_ovf got=%b want=0", o_ovf); end
        checks++; if (o_issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%b want=1", o_issue_ready); end
        cycle();
    endtask

    // Single issue; o_valid must rise exactly 8 cycles later with the given word.
    task automatic test_single(input logic [71:0] vec, input logic sgn, input logic [3:0] sh,
                               input logic [31:0] want_data, input logic [3:0] want_sat);
        i_ready = 1'b1; i_signed = sgn; i_shift = sh; cur_vec = vec; i_issue = 1'b1;
        cycle();
        i_issue = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cur_vec = rand_vec();
            checks++;
            if (o_valid !== (k == 8)) begin
                failures++; $display("FAIL single_latency k=%0d got=%b want=%b", k, o_valid, k == 8);
            end
            if (k == 8) begin
                checks++; if (o_data !== want_data) begin failures++; $display("FAIL single_data got=%h want=%h", o_data, want_data); end
                checks++; if (o_sat !== want_sat)   begin failures++; $display("FAIL single_sat got=%b want=%b", o_sat, want_sat); end
            end else begin
                cycle();
            end
        end
        cycle(); cycle();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cur_vec = rand_vec(); i_signed = 1'($urandom); i_shift = 4'($urandom); i_issue = 1'b1;
            checks++;
            if (o_issue_ready !== (i < 4)) begin
                failures++; $display("FAIL bp_issue_ready i=%0d got=%b want=%b", i, o_issue_ready, i < 4);
            end
            cycle();
        end
        i_issue = 1'b0;
        repeat (LAT + 1) cycle();
        checks++; if (o_ovf !== 1'b1)   begin failures++; $display("FAIL bp_ovf got=%b want=1", o_ovf); end
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b want=1", o_valid); end
        i_ready = 1'b1;
        repeat (6) cycle();
        checks++; if (o_valid !== 1'b0)       begin failures++; $display("FAIL bp_drained got=%b want=0", o_valid); end
        checks++; if (o_issue_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b want=1", o_issue_ready); end
    endtask

    task automatic test_pop_issue_same_cycle();
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur_vec = rand_vec(); i_signed = 1'($urandom); i_shift = 4'($urandom); i_issue = 1'b1;
            cycle();
        end
        i_issue = 1'b0;
        repeat (LAT + 1) cycle();
        checks++; if (o_issue_ready !== 1'b0) begin failures++; $display("FAIL pi_full_ready got=%b want=0", o_issue_ready); end
        i_ready = 1'b1; i_issue = 1'b1; cur_vec = rand_vec();
        cycle();
        i_ready = 1'b0;
        checks++; if (o_issue_ready !== 1'b1) begin failures++; $display("FAIL pi_room_after_pop got=%b want=1", o_issue_ready); end
        cur_vec = rand_vec();
        cycle();
        i_issue = 1'b0;
        checks++; if (o_issue_ready !== 1'b0) begin failures++; $display("FAIL pi_refilled got=%b want=0", o_issue_ready); end
        i_ready = 1'b1;
        repeat (LAT + 6) cycle();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL pi_drained got=%b want=0", o_valid); end
    endtask

    task automatic test_reset_inflight();
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur_vec = rand_vec() | 72'h1; i_signed = 1'($urandom); i_shift = 4'($urandom); i_issue = 1'b1;
            cycle();
        end
        i_issue = 1'b0;
        cycle();
        i_nrst = 1'b0;
        cycle();
        i_nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cur_vec = rand_vec() | 72'h1;
            checks++; if (o_valid !== 1'b0)       begin failures++; $display("FAIL ri_valid i=%0d got=%b want=0", i, o_valid); end
            checks++; if (o_issue_ready !== 1'b1) begin failures++; $display("FAIL ri_issue_ready i=%0d got=%b want=1", i, o_issue_ready); end
            cycle();
        end
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 400; i++) begin
            cur_vec  = rand_vec();
            i_issue  = ($urandom_range(0, 9) < 7);
            i_signed = 1'($urandom);
            i_shift  = 4'($urandom);
            i_ready  = ($urandom_range(0, 9) < 6);
            cycle();
        end
        i_issue = 1'b0; i_ready = 1'b1;
        repeat (LAT + 8) cycle();
        checks++; if (o_valid !== 1'b0)       begin failures++; $display("FAIL rnd_drained got=%b want=0", o_valid); end
        checks++; if (o_issue_ready !== 1'b1) begin failures++; $display("FAIL rnd_issue_ready got=%b want=1", o_issue_ready); end
    endtask

    initial begin
        cur_vec = '0;
        for (int i = 0; i < LAT; i++) mpipe[i] = rand_vec();
        m_res = 0; m_cnt = 0; m_pipe = '0; m_ovf = 1'b0;
        test_reset();
        test_single({18'h3FF00, 18'd200, 18'd100, 18'h3FFFF}, 1'b1, 4'd0, 32'h807F64FF, 4'b1100);
        test_single({18'd8, 18'd7, 18'h3FFFF, 18'd24}, 1'b0, 4'd4, 32'h0100FF02, 4'b0010);
        test_backpressure();
        test_pop_issue_same_cycle();
        test_reset_inflight();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
